// File: rtl/snake_timing_pkg.sv
// rtl/snake_timing_pkg.sv - shared timing types and defaults for the snake step timer
package snake_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} step_state_t;

  localparam int DEFAULT_BASE_DIV = 12_500_000;
  localparam int DEFAULT_DIV_STEP = 1_250_000;
  localparam int SPEED_W          = 3;

endpackage

// File: rtl/snake_period_lut.sv
// rtl/snake_period_lut.sv - speed level to step period mapping
module snake_period_lut
  import snake_timing_pkg::*;
#(
  parameter int BASE_DIV = DEFAULT_BASE_DIV,
  parameter int DIV_STEP = DEFAULT_DIV_STEP,
  parameter int CNT_W    = 24
) (
  input  logic [SPEED_W-1:0] speed_i,
  output logic [CNT_W-1:0]   period_o
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(DIV_STEP);

  assign period_o = BASE - CNT_W'(speed_i) * STEP;

endmodule

// File: rtl/snake_step_timer.sv
// rtl/snake_step_timer.sv - programmable step-rate tick generator with run/pause/single-step
module snake_step_timer
  import snake_timing_pkg::*;
#(
  parameter int BASE_DIV = DEFAULT_BASE_DIV,
  parameter int DIV_STEP = DEFAULT_DIV_STEP,
  parameter int CNT_W    = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause_toggle,
  input  logic               step_req,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick,
  output logic               running,
  output logic               paused
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  step_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] lut_period;
  logic             tick_q;
  logic             running_q;
  logic             paused_q;

  snake_period_lut #(
    .BASE_DIV (BASE_DIV),
    .DIV_STEP (DIV_STEP),
    .CNT_W    (CNT_W)
  ) u_lut (
    .speed_i  (speed),
    .period_o (lut_period)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= PER_RST;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (stop) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        running_q <= 1'b0;
        paused_q  <= 1'b0;
      end else if (start) begin
        state_q   <= RUN;
        cnt_q     <= '0;
        per_q     <= lut_period;
        running_q <= 1'b1;
        paused_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: cnt_q <= '0;
          // The pause edge itself does not advance cnt, so no wrap can fire on it.
          RUN: begin
            if (pause_toggle) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end else if (cnt_q == per_q - ONE) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              per_q  <= lut_period;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          PAUSED: begin
            if (pause_toggle) begin
              state_q   <= RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end else if (step_req) begin
              tick_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign paused  = paused_q;

endmodule

// File: tb/tb_snake_step_timer.sv
// tb/tb_snake_step_timer.sv - scoreboard bench for snake_step_timer
module tb_snake_step_timer;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause_toggle = 1'b0;
  logic       step_req = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       tick;
  logic       running;
  logic       paused;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = M_IDLE;
  int rem = 0;
  int sb[$];

  snake_step_timer #(
    .BASE_DIV (20),
    .DIV_STEP (2),
    .CNT_W    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .pause_toggle (pause_toggle),
    .step_req     (step_req),
    .speed        (speed),
    .tick         (tick),
    .running      (running),
    .paused       (paused)
  );

  always #5 clock = ~clock;

  function automatic int period_of(input int level);
    return 20 - 2 * level;
  endfunction

  // Reference: rem counts RUN edges left until the next tick.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mode = M_IDLE;
      rem = 0;
      sb.delete();
    end else begin
      cyc++;
      if (stop) begin
        mode = M_IDLE;
      end else if (start) begin
        mode = M_RUN;
        rem = period_of(int'(speed));
      end else if (mode == M_RUN) begin
        if (pause_toggle) begin
          mode = M_PAUSED;
        end else begin
          rem--;
          if (rem == 0) begin
            sb.push_back(cyc);
            rem = period_of(int'(speed));
          end
        end
      end else if (mode == M_PAUSED) begin
        if (pause_toggle) mode = M_RUN;
        else if (step_req) sb.push_back(cyc);
      end
    end
  end

  always @(negedge clock) begin
    logic exp_tick;
    exp_tick = 1'b0;
    if (sb.size() > 0 && sb[0] == cyc) begin
      exp_tick = 1'b1;
      void'(sb.pop_front());
    end
    n_checks++;
    if (tick !== exp_tick) begin
      n_fail++;
      $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick);
    end
    n_checks++;
    if (running !== (mode == M_RUN) || paused !== (mode == M_PAUSED)) begin
      n_fail++;
      $display("FAIL state cyc=%0d got running=%b paused=%b exp mode=%0d", cyc, running, paused, mode);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input bit st, input bit sp, input bit pt, input bit sr);
    start = st;
    stop = sp;
    pause_toggle = pt;
    step_req = sr;
    @(negedge clock);
    start = 1'b0;
    stop = 1'b0;
    pause_toggle = 1'b0;
    step_req = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (tick === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_tick got=no tick exp=tick within 60 cycles");
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);

    // Period at speed 0, then a mid-period speed change to 7
    pulse(1, 0, 0, 0);
    wait_cycles(70);
    wait_cycles(10);
    speed = 3'd7;
    wait_cycles(40);
    speed = 3'd0;

    // Pause five cycles after a tick, hold, resume
    wait_tick();
    wait_cycles(4);
    pulse(0, 0, 1, 0);
    wait_cycles(30);
    pulse(0, 0, 1, 0);
    wait_cycles(45);

    // Single steps while paused, then step coinciding with resume
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, 0, 1);
      wait_cycles(3);
    end
    pulse(0, 0, 1, 1);
    wait_cycles(10);
    pulse(0, 0, 0, 1);
    wait_cycles(5);

    // Stop beats start; restart mid-period
    pulse(1, 1, 0, 0);
    wait_cycles(100);
    pulse(1, 0, 0, 0);
    wait_cycles(10);
    pulse(1, 0, 0, 0);
    wait_cycles(30);

    // Asynchronous reset while tick is high
    wait_tick();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (tick !== 1'b0 || running !== 1'b0 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got tick=%b running=%b paused=%b exp=0", tick, running, paused);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_cycles(40);
    pulse(0, 0, 1, 1);
    wait_cycles(25);

    // Random control traffic
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 59) == 0);
      stop = ($urandom_range(0, 199) == 0);
      pause_toggle = ($urandom_range(0, 24) == 0);
      step_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) speed = 3'($urandom_range(0, 7));
      @(negedge clock);
    end
    start = 1'b0;
    stop = 1'b0;
    pause_toggle = 1'b0;
    step_req = 1'b0;
    wait_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
